// File: rtl/blackbox_pkg.sv
// Shared constants and types for the blackbox self-check sweeper.
package blackbox_pkg;

   // Expected blackbox truth table: j = ~o & (~i | h), bit k is vector {i,h,o} = k.
   localparam logic [7:0] BB_GOLDEN_TT = 8'h45;

   // The blackbox has three inputs, so a full sweep covers eight vectors.
   localparam int unsigned BB_NUM_VECTORS = 8;
   localparam logic [2:0]  BB_LAST_VEC    = 3'(BB_NUM_VECTORS - 1);

   // Sweep controller states.
   typedef enum logic [1:0] {
      BB_IDLE   = 2'd0,
      BB_SETTLE = 2'd1,
      BB_SAMPLE = 2'd2
   } bb_sweep_state_t;

endpackage

// File: rtl/blackbox_sweeper_settle_timer.sv
// Loadable 8-bit down-counter that times how long each vector settles.
module settle_timer (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load_i,
   input  logic [7:0] load_val_i,
   input  logic       dec_i,
   output logic       zero_o
);

   logic [7:0] cnt_q;
   logic [7:0] cnt_d;

   // Load takes priority over decrement; the counter saturates at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 8'd1;
      end
   end

   // Counter register, cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/blackbox_sweeper.sv
// Sweeps all eight blackbox input vectors, captures j into a truth table
// and compares the result against the golden table.
module blackbox_sweeper
   import blackbox_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 1,
   parameter logic [7:0]  GOLDEN        = BB_GOLDEN_TT
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   output logic       i,
   output logic       h,
   output logic       o,
   input  logic       j,
   output logic       busy,
   output logic       sample_valid,
   output logic [2:0] sample_idx,
   output logic       done,
   output logic       aborted,
   output logic [7:0] truth_table,
   output logic       match
);

   localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES);

   bb_sweep_state_t state_q, state_d;
   logic [2:0] vec_q,   vec_d;
   logic [2:0] iho_q,   iho_d;
   logic [7:0] tt_q,    tt_d;
   logic       match_q, match_d;
   logic       sv_q,    sv_d;
   logic [2:0] sidx_q,  sidx_d;
   logic       done_q,  done_d;
   logic       abt_q,   abt_d;

   logic       tmr_load;
   logic       tmr_dec;
   logic       tmr_zero;

   settle_timer u_settle_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (tmr_load),
      .load_val_i (SETTLE_LOAD),
      .dec_i      (tmr_dec),
      .zero_o     (tmr_zero)
   );

   // Next-state logic: abort pre-empts both settling and sampling, so a
   // cancelled final SAMPLE neither captures j nor raises done.
   always_comb begin
      state_d  = state_q;
      vec_d    = vec_q;
      tt_d     = tt_q;
      match_d  = match_q;
      sv_d     = 1'b0;
      sidx_d   = sidx_q;
      done_d   = 1'b0;
      abt_d    = 1'b0;
      tmr_load = 1'b0;
      tmr_dec  = 1'b0;

      unique case (state_q)
         BB_IDLE: begin
            if (start) begin
               state_d  = BB_SETTLE;
               vec_d    = '0;
               tt_d     = '0;
               match_d  = 1'b0;
               tmr_load = 1'b1;
            end
         end
         BB_SETTLE: begin
            if (abort) begin
               state_d = BB_IDLE;
               vec_d   = '0;
               match_d = 1'b0;
               abt_d   = 1'b1;
            end else if (tmr_zero) begin
               state_d = BB_SAMPLE;
            end else begin
               tmr_dec = 1'b1;
            end
         end
         BB_SAMPLE: begin
            if (abort) begin
               state_d = BB_IDLE;
               vec_d   = '0;
               match_d = 1'b0;
               abt_d   = 1'b1;
            end else begin
               tt_d[vec_q] = j;
               sv_d        = 1'b1;
               sidx_d      = vec_q;
               if (vec_q == BB_LAST_VEC) begin
                  state_d = BB_IDLE;
                  vec_d   = '0;
                  done_d  = 1'b1;
                  match_d = (tt_d == GOLDEN);
               end else begin
                  state_d  = BB_SETTLE;
                  vec_d    = vec_q + 3'd1;
                  tmr_load = 1'b1;
               end
            end
         end
         default: begin
            state_d = BB_IDLE;
            vec_d   = '0;
         end
      endcase

      // Blackbox inputs follow the vector being swept and park at zero in IDLE.
      iho_d = (state_d == BB_IDLE) ? '0 : vec_d;
   end

   // State and registered outputs, cleared asynchronously with no pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= BB_IDLE;
         vec_q   <= '0;
         iho_q   <= '0;
         tt_q    <= '0;
         match_q <= 1'b0;
         sv_q    <= 1'b0;
         sidx_q  <= '0;
         done_q  <= 1'b0;
         abt_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         iho_q   <= iho_d;
         tt_q    <= tt_d;
         match_q <= match_d;
         sv_q    <= sv_d;
         sidx_q  <= sidx_d;
         done_q  <= done_d;
         abt_q   <= abt_d;
      end
   end

   assign i            = iho_q[2];
   assign h            = iho_q[1];
   assign o            = iho_q[0];
   assign busy         = (state_q != BB_IDLE);
   assign sample_valid = sv_q;
   assign sample_idx   = sidx_q;
   assign done         = done_q;
   assign aborted      = abt_q;
   assign truth_table  = tt_q;
   assign match        = match_q;

endmodule
